// File: rtl/axi_w_router.sv
// axi_w_router: routes the AXI W channel of one master to NUM_S slaves or to
//   an internal decode-error sink, following the order of accepted AW beats.
// Latency: zero-cycle combinational routing (WVALID_M->WVALID_S, WREADY_S->WREADY_M);
//   an AW beat's route becomes usable the cycle after aw_hs.
// Backpressure: W stalls (WREADY_M=0) while no route is queued; aw_full asks
//   the AW channel to hold off; an aw_hs while full is dropped and flagged.
// Ports: ACLK/ARESET (sync, active high); aw_addr/aw_len/aw_hs route request,
//   aw_full; master W (WDATA_M..WREADY_M); per-slave W (WDATA_S..WREADY_S);
//   status pulses burst_done, decerr, last_err, ovf_err.
module axi_w_router #(
  parameter int NUM_S  = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [NUM_S*ADDR_W-1:0] S_BASE  =
    {32'h0005_0000, 32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
  parameter logic [NUM_S*ADDR_W-1:0] S_LIMIT =
    {32'h0006_0000, 32'h0005_0000, 32'h0004_0000, 32'h0003_0000, 32'h0002_0000}
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_W-1:0]          aw_addr,
  input  logic [7:0]                 aw_len,
  input  logic                       aw_hs,
  output logic                       aw_full,
  input  logic [DATA_W-1:0]          WDATA_M,
  input  logic [DATA_W/8-1:0]        WSTRB_M,
  input  logic                       WLAST_M,
  input  logic                       WVALID_M,
  output logic                       WREADY_M,
  output logic [NUM_S*DATA_W-1:0]    WDATA_S,
  output logic [NUM_S*DATA_W/8-1:0]  WSTRB_S,
  output logic [NUM_S-1:0]           WLAST_S,
  output logic [NUM_S-1:0]           WVALID_S,
  input  logic [NUM_S-1:0]           WREADY_S,
  output logic                       burst_done,
  output logic                       decerr,
  output logic                       last_err,
  output logic                       ovf_err
);

  localparam int SEL_W = $clog2(NUM_S + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_mem_q [DEPTH];
  logic [7:0]        len_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;

  logic [SEL_W-1:0]  dec_sel;
  logic [SEL_W-1:0]  hsel;
  logic [7:0]        hlen;
  logic              push, pop, w_hs, final_beat, to_sink;

  // Address decode; scanning downward lets the lowest matching slave win.
  always_comb begin
    dec_sel = SEL_W'(NUM_S);
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if (aw_addr >= S_BASE[i*ADDR_W +: ADDR_W] && aw_addr < S_LIMIT[i*ADDR_W +: ADDR_W])
        dec_sel = SEL_W'(i);
    end
  end

  assign aw_full    = (count_q == CNT_W'(DEPTH));
  assign push       = aw_hs & ~aw_full;
  assign ovf_err    = aw_hs & aw_full;
  assign hsel       = sel_mem_q[rd_ptr_q];
  assign hlen       = len_mem_q[rd_ptr_q];
  assign to_sink    = (hsel == SEL_W'(NUM_S));
  assign final_beat = (beat_cnt_q == hlen);

  // Data, strobe and last are broadcast; only valid is steered.
  assign WDATA_S = {NUM_S{WDATA_M}};
  assign WSTRB_S = {NUM_S{WSTRB_M}};
  assign WLAST_S = {NUM_S{WLAST_M}};

  // Next-state and routing. Handshake and pop are resolved before the state
  // decision so that the last queued route returns to IDLE on its final beat.
  always_comb begin
    state_d    = state_q;
    WREADY_M   = 1'b0;
    WVALID_S   = '0;
    w_hs       = 1'b0;
    pop        = 1'b0;
    burst_done = 1'b0;
    decerr     = 1'b0;
    last_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (push) state_d = BURST;
      end
      BURST: begin
        if (to_sink) begin
          WREADY_M = 1'b1;
        end else begin
          for (int i = 0; i < NUM_S; i++) begin
            if (hsel == SEL_W'(i)) begin
              WREADY_M    = WREADY_S[i];
              WVALID_S[i] = WVALID_M;
            end
          end
        end
        w_hs = WVALID_M & WREADY_M;
        if (w_hs) begin
          // The beat count, not WLAST_M, decides where the burst ends.
          last_err = (WLAST_M != final_beat);
          if (final_beat) begin
            pop        = 1'b1;
            burst_done = 1'b1;
            decerr     = to_sink;
            if (count_q == CNT_W'(1) && !push) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    beat_cnt_d = beat_cnt_q;
    if (pop)       beat_cnt_d = '0;
    else if (w_hs) beat_cnt_d = beat_cnt_q + 8'd1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Route storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge ACLK) begin
    if (push) begin
      sel_mem_q[wr_ptr_q] <= dec_sel;
      len_mem_q[wr_ptr_q] <= aw_len;
    end
  end

endmodule
